class_argmax: RTL and testbench

- Sits directly downstream of the per-class signed accumulators, one per class.
- Captures all NUM_CLASSES signed class sums on a start pulse and scans them sequentially, one class per cycle.
- Reports the winning class index, its sum, and a tie indication.
- Output is the final inference decision of the Tsetlin machine datapath.

---
 rtl/class_argmax.sv | 127 ++++++++++++
 tb/tb_class_argmax.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/class_argmax.sv
// Final-decision argmax for the Tsetlin machine: captures every class sum on start,
// then scans one class per cycle to find the highest sum, its index and any tie.
module class_argmax #(
    parameter int NUM_CLASSES = 10,
    parameter int SUM_WIDTH   = 32,
    parameter int IDX_WIDTH   = 4
) (
    input  logic                             clk,
    input  logic                             rst_flag,
    input  logic                             start,
    input  logic [NUM_CLASSES*SUM_WIDTH-1:0] class_sums_flat,
    output logic                             busy,
    output logic                             done,
    output logic [IDX_WIDTH-1:0]             pred_class,
    output logic [SUM_WIDTH-1:0]             pred_sum,
    output logic                             tie
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

    state_t state_reg, state_next;

    logic signed [SUM_WIDTH-1:0] bank_reg [NUM_CLASSES];
    logic signed [SUM_WIDTH-1:0] best_sum_reg, best_sum_next;
    logic [IDX_WIDTH-1:0]        best_idx_reg, best_idx_next;
    logic                        tie_reg, tie_next;
    logic [IDX_WIDTH-1:0]        idx_reg, idx_next;

    logic [IDX_WIDTH-1:0]        pred_class_reg;
    logic [SUM_WIDTH-1:0]        pred_sum_reg;
    logic                        pred_tie_reg;

    logic                        accept;
    logic signed [SUM_WIDTH-1:0] scan_sum;
    logic signed [SUM_WIDTH-1:0] first_sum;

    assign accept    = (state_reg == IDLE) && start;
    assign scan_sum  = bank_reg[idx_reg];
    assign first_sum = $signed(class_sums_flat[SUM_WIDTH-1:0]);

    // Capture bank: all classes are latched in parallel on an accepted start.
    generate
        for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_bank
            always_ff @(posedge clk) begin
                if (rst_flag) begin
                    bank_reg[gi] <= '0;
                end else if (accept) begin
                    bank_reg[gi] <= $signed(class_sums_flat[gi*SUM_WIDTH +: SUM_WIDTH]);
                end
            end
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        best_sum_next = best_sum_reg;
        best_idx_next = best_idx_reg;
        tie_next      = tie_reg;
        idx_next      = idx_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    best_sum_next = first_sum;
                    best_idx_next = '0;
                    tie_next      = 1'b0;
                    idx_next      = IDX_WIDTH'(1);
                    state_next    = (NUM_CLASSES == 1) ? DONE : SCAN;
                end
            end
            SCAN: begin
                // Strictly-greater replaces the best, so the lowest index wins ties.
                if (scan_sum > best_sum_reg) begin
                    best_sum_next = scan_sum;
                    best_idx_next = idx_reg;
                    tie_next      = 1'b0;
                end else if (scan_sum == best_sum_reg) begin
                    tie_next      = 1'b1;
                end
                if (idx_reg == LAST_IDX) begin
                    state_next = DONE;
                end else begin
                    idx_next   = idx_reg + IDX_WIDTH'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_flag) begin
            state_reg      <= IDLE;
            best_sum_reg   <= '0;
            best_idx_reg   <= '0;
            tie_reg        <= 1'b0;
            idx_reg        <= '0;
            pred_class_reg <= '0;
            pred_sum_reg   <= '0;
            pred_tie_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            best_sum_reg <= best_sum_next;
            best_idx_reg <= best_idx_next;
            tie_reg      <= tie_next;
            idx_reg      <= idx_next;
            // Results load with the final compare folded in, on the edge entering DONE.
            if (state_next == DONE) begin
                pred_class_reg <= best_idx_next;
                pred_sum_reg   <= best_sum_next;
                pred_tie_reg   <= tie_next;
            end
        end
    end

    assign busy       = (state_reg != IDLE);
    assign done       = (state_reg == DONE);
    assign pred_class = pred_class_reg;
    assign pred_sum   = pred_sum_reg;
    assign tie        = pred_tie_reg;

endmodule

// File: tb/tb_class_argmax.sv
// Directed bench for class_argmax: hand-computed argmax results, latency, busy
// window, input isolation while busy, and reset behaviour.
module tb_class_argmax;

    localparam int N  = 10;
    localparam int SW = 32;
    localparam int IW = 4;

    logic            clk = 1'b0;
    logic            rst_flag;
    logic            start;
    logic [N*SW-1:0] class_sums_flat;
    logic            busy;
    logic            done;
    logic [IW-1:0]   pred_class;
    logic [SW-1:0]   pred_sum;
    logic            tie;

    logic [SW-1:0]   sums [N];
    int              n_assert = 0;
    int              n_fail   = 0;

    class_argmax #(.NUM_CLASSES(N), .SUM_WIDTH(SW), .IDX_WIDTH(IW)) dut (
        .clk             (clk),
        .rst_flag        (rst_flag),
        .start           (start),
        .class_sums_flat (class_sums_flat),
        .busy            (busy),
        .done            (done),
        .pred_class      (pred_class),
        .pred_sum        (pred_sum),
        .tie             (tie)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pack_sums();
        for (int k = 0; k < N; k++) class_sums_flat[k*SW +: SW] = sums[k];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One scan; with poke set, start is re-pulsed mid-scan and in the done cycle
    // while the sums are changed underneath the capture.
    task automatic run_scan(input string tag, input logic [IW-1:0] exp_cls,
                            input logic [SW-1:0] exp_sum, input logic exp_tie,
                            input bit poke);
        int cyc;
        int busy_cnt;
        start = 1'b1;
        tick();
        start    = 1'b0;
        cyc      = 0;
        busy_cnt = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) busy_cnt++;
            if (poke && cyc == 2) begin
                start = 1'b1;
                sums[3] = 32'd5000;
                sums[7] = 32'd0;
                pack_sums();
            end
            tick();
            start = 1'b0;
            cyc++;
        end
        if (busy === 1'b1) busy_cnt++;
        check({tag, "_latency"}, cyc + 1, N);
        check({tag, "_busy_cycles"}, busy_cnt, N);
        check({tag, "_pred_class"}, pred_class, exp_cls);
        check({tag, "_pred_sum"}, pred_sum, exp_sum);
        check({tag, "_tie"}, tie, exp_tie);
        $display("%s: class=%0d sum=%0d tie=%0b latency=%0d", tag, pred_class,
                 $signed(pred_sum), tie, cyc + 1);
        if (poke) start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_done_after"}, done, 1'b0);
        check({tag, "_busy_after"}, busy, 1'b0);
    endtask

    task automatic count_done(input string tag, input int cycles, input logic [SW-1:0] hold_sum);
        int pulses;
        int busy_seen;
        pulses    = 0;
        busy_seen = 0;
        for (int c = 0; c < cycles; c++) begin
            tick();
            if (done === 1'b1) pulses++;
            if (busy === 1'b1) busy_seen++;
        end
        check({tag, "_extra_done"}, pulses, 0);
        check({tag, "_extra_busy"}, busy_seen, 0);
        check({tag, "_hold_sum"}, pred_sum, hold_sum);
    endtask

    initial begin
        rst_flag        = 1'b1;
        start           = 1'b1;
        class_sums_flat = '0;
        for (int k = 0; k < N; k++) sums[k] = '0;
        tick();
        tick();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_pred_class", pred_class, 4'd0);
        check("rst_pred_sum", pred_sum, 32'd0);
        check("rst_tie", tie, 1'b0);
        rst_flag = 1'b0;
        start    = 1'b0;
        tick();
        check("rst_start_not_accepted", busy, 1'b0);
        $display("reset: busy=%0b done=%0b class=%0d sum=%0d tie=%0b", busy, done, pred_class, pred_sum, tie);

        for (int k = 0; k < N; k++) sums[k] = 32'(10 * k - 45);
        sums[7] = 32'd1000;
        pack_sums();
        run_scan("distinct", 4'd7, 32'd1000, 1'b0, 1'b0);

        for (int k = 0; k < N; k++) sums[k] = '0;
        sums[2] = 32'd300;
        sums[5] = 32'd300;
        pack_sums();
        run_scan("tie_2_5", 4'd2, 32'd300, 1'b1, 1'b0);
        sums[8] = 32'd301;
        pack_sums();
        run_scan("tie_broken", 4'd8, 32'd301, 1'b0, 1'b0);

        for (int k = 0; k < N; k++) sums[k] = 32'(-(k + 1));
        pack_sums();
        run_scan("all_neg", 4'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        for (int k = 0; k < N; k++) sums[k] = 32'hFFFF_FFFB;
        pack_sums();
        run_scan("all_eq_m5", 4'd0, 32'hFFFF_FFFB, 1'b1, 1'b0);

        for (int k = 0; k < N; k++) sums[k] = '0;
        sums[0] = 32'h8000_0000;
        sums[9] = 32'h7FFF_FFFF;
        pack_sums();
        run_scan("extremes", 4'd9, 32'h7FFF_FFFF, 1'b0, 1'b0);

        for (int k = 0; k < N; k++) sums[k] = 32'(10 * k - 45);
        sums[7] = 32'd1000;
        pack_sums();
        run_scan("isolation", 4'd7, 32'd1000, 1'b0, 1'b1);
        count_done("isolation", 15, 32'd1000);

        sums[7] = 32'd1000;
        sums[3] = 32'd0;
        pack_sums();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst_flag = 1'b1;
        tick();
        rst_flag = 1'b0;
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_pred_class", pred_class, 4'd0);
        check("midrst_pred_sum", pred_sum, 32'd0);
        check("midrst_tie", tie, 1'b0);
        $display("mid_scan_reset: busy=%0b done=%0b class=%0d sum=%0d tie=%0b", busy, done, pred_class, pred_sum, tie);
        count_done("midrst", 15, 32'd0);

        for (int k = 0; k < N; k++) sums[k] = '0;
        sums[4] = 32'd77;
        sums[6] = 32'd77;
        pack_sums();
        run_scan("after_rst", 4'd4, 32'd77, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
